// File: rtl/cache_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cache_ctrl : direct-mapped read-only cache in front of mainMem (4-word    |
// | lines). Optional CACHE_STATS_EN adds access/hit counters. Rev 1.0         |
// +--------------------------------------------------------------------------+
module cache_ctrl #(
  parameter int ADR_W   = 15,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADR_W-1:0]  cpu_adr,
  output logic [DATA_W-1:0] cpu_data,
  output logic              cpu_ready,
  output logic              cpu_hit,
  output logic              mem_read,
  output logic [ADR_W-1:0]  mem_adr,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_data1,
  input  logic [DATA_W-1:0] mem_data2,
  input  logic [DATA_W-1:0] mem_data3,
  input  logic [DATA_W-1:0] mem_data4
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]       acc_cnt,
  output logic [15:0]       hit_cnt
`endif
);

  localparam int c_TAG_W = ADR_W - INDEX_W - 2;
  localparam int c_LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOOKUP    = 2'd1,
    S_MISS_WAIT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADR_W-1:0]    r_adr;
  logic                r_first;
  logic [c_LINES-1:0]  r_valid;
  logic [c_TAG_W-1:0]  r_tag [c_LINES];
  logic [DATA_W-1:0]   r_mem [c_LINES*4];

  logic [c_TAG_W-1:0]  w_tag;
  logic [INDEX_W-1:0]  w_idx;
  logic [1:0]          w_off;
  logic                w_hit;
  logic                w_fill;
  logic [DATA_W-1:0]   w_refill_word;
  logic [DATA_W-1:0]   w_data_nxt;
  logic                w_ready_nxt;
  logic                w_hit_nxt;
  logic                w_read_nxt;
  logic [ADR_W-1:0]    w_madr_nxt;

  assign w_tag = r_adr[ADR_W-1:INDEX_W+2];
  assign w_idx = r_adr[INDEX_W+1:2];
  assign w_off = r_adr[1:0];
  assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  // done seen on the first MISS_WAIT edge belongs to the previous transaction
  assign w_fill = (r_state == S_MISS_WAIT) && !r_first && mem_done;

  always_comb begin
    case (w_off)
      2'd0:    w_refill_word = mem_data1;
      2'd1:    w_refill_word = mem_data2;
      2'd2:    w_refill_word = mem_data3;
      default: w_refill_word = mem_data4;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = cpu_data;
    w_ready_nxt = 1'b0;
    w_hit_nxt   = 1'b0;
    w_read_nxt  = mem_read;
    w_madr_nxt  = mem_adr;
    case (r_state)
      S_IDLE: begin
        if (cpu_req) w_state_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (w_hit) begin
          w_data_nxt  = r_mem[{w_idx, w_off}];
          w_ready_nxt = 1'b1;
          w_hit_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_read_nxt  = 1'b1;
          w_madr_nxt  = {w_tag, w_idx, 2'b00};
          w_state_nxt = S_MISS_WAIT;
        end
      end
      S_MISS_WAIT: begin
        if (w_fill) begin
          w_read_nxt  = 1'b0;
          w_data_nxt  = w_refill_word;
          w_ready_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_adr     <= '0;
      r_first   <= 1'b0;
      r_valid   <= '0;
      cpu_data  <= '0;
      cpu_ready <= 1'b0;
      cpu_hit   <= 1'b0;
      mem_read  <= 1'b0;
      mem_adr   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_first   <= (r_state == S_LOOKUP) && (w_state_nxt == S_MISS_WAIT);
      cpu_data  <= w_data_nxt;
      cpu_ready <= w_ready_nxt;
      cpu_hit   <= w_hit_nxt;
      mem_read  <= w_read_nxt;
      mem_adr   <= w_madr_nxt;
      if (r_state == S_IDLE && cpu_req) r_adr <= cpu_adr;
      if (w_fill) r_valid[w_idx] <= 1'b1;
    end
  end

  // Tag/data arrays carry no reset; the valid bits alone qualify them
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_idx]             <= w_tag;
      r_mem[{w_idx, 2'd0}]     <= mem_data1;
      r_mem[{w_idx, 2'd1}]     <= mem_data2;
      r_mem[{w_idx, 2'd2}]     <= mem_data3;
      r_mem[{w_idx, 2'd3}]     <= mem_data4;
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] r_acc_cnt;
  logic [15:0] r_hit_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_cnt <= '0;
      r_hit_cnt <= '0;
    end else if (cpu_ready) begin
      r_acc_cnt <= r_acc_cnt + 16'd1;
      if (cpu_hit) r_hit_cnt <= r_hit_cnt + 16'd1;
    end
  end

  assign acc_cnt = r_acc_cnt;
  assign hit_cnt = r_hit_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cache_ctrl : scoreboard bench for cache_ctrl with a mainMem model      |
// | (Memory[i]=i). Rev 1.0                                                   |
// +--------------------------------------------------------------------------+
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [14:0] cpu_adr;
  logic [31:0] cpu_data;
  logic        cpu_ready;
  logic        cpu_hit;
  logic        mem_read;
  logic [14:0] mem_adr;
  logic        mem_done = 1'b0;
  logic [31:0] mem_data1 = '0;
  logic [31:0] mem_data2 = '0;
  logic [31:0] mem_data3 = '0;
  logic [31:0] mem_data4 = '0;
`ifdef CACHE_STATS_EN
  logic [15:0] acc_cnt;
  logic [15:0] hit_cnt;
`endif

  cache_ctrl dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_adr(cpu_adr),
    .cpu_data(cpu_data), .cpu_ready(cpu_ready), .cpu_hit(cpu_hit),
    .mem_read(mem_read), .mem_adr(mem_adr), .mem_done(mem_done),
    .mem_data1(mem_data1), .mem_data2(mem_data2),
    .mem_data3(mem_data3), .mem_data4(mem_data4)
`ifdef CACHE_STATS_EN
    , .acc_cnt(acc_cnt), .hit_cnt(hit_cnt)
`endif
  );

  always #5 clk = ~clk;

  // mainMem model: done rises one cycle after read and stays high afterwards,
  // so a new miss sees a stale done on its first MISS_WAIT edge.
  always @(posedge clk) begin
    if (mem_read) begin
      mem_done  <= 1'b1;
      mem_data1 <= 32'(mem_adr);
      mem_data2 <= 32'(mem_adr) + 32'd1;
      mem_data3 <= 32'(mem_adr) + 32'd2;
      mem_data4 <= 32'(mem_adr) + 32'd3;
    end
  end

  typedef struct {
    logic [31:0] data;
    logic        hit;
    int          lat;
    time         t;
  } exp_t;

  exp_t        rq[$];
  logic [14:0] mq[$];
  int          vectors = 0;
  int          errors  = 0;
  logic        prev_rd = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endfunction

  // Monitor: pops expected responses / memory requests as the DUT presents them
  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_ready) begin
        chk("resp_pending", 32'(rq.size() != 0), 32'd1);
        if (rq.size() != 0) begin
          exp_t e;
          e = rq.pop_front();
          chk("cpu_data", cpu_data, e.data);
          chk("cpu_hit", 32'(cpu_hit), 32'(e.hit));
          chk("latency", 32'(int'(($time - e.t + 5) / 10)), 32'(e.lat));
        end
      end
      if (mem_read && !prev_rd) begin
        chk("memreq_pending", 32'(mq.size() != 0), 32'd1);
        if (mq.size() != 0) chk("mem_adr", 32'(mem_adr), 32'(mq.pop_front()));
      end
    end
    prev_rd = mem_read;
  end

  // Called at a negedge; returns at the negedge where cpu_ready is seen.
  task automatic req(input logic [14:0] adr, input logic [31:0] data,
                     input logic hit, input logic hold);
    exp_t e;
    bit   seen;
    cpu_adr = adr;
    cpu_req = 1'b1;
    @(posedge clk);
    e.data = data; e.hit = hit; e.lat = hit ? 2 : 4; e.t = $time;
    rq.push_back(e);
    if (!hit) mq.push_back({adr[14:2], 2'b00});
    #1;
    if (!hold) cpu_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = cpu_ready;
    end
    chk("ready_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_adr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu_data", cpu_data, 32'd0);
    chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    chk("rst_cpu_hit", 32'(cpu_hit), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_adr", 32'(mem_adr), 32'd0);
    @(negedge clk) rst = 1'b0;

    req(15'h0005, 32'h5, 1'b0, 1'b0);      // cold miss
    req(15'h0007, 32'h7, 1'b1, 1'b0);      // hit in filled line
    req(15'h0404, 32'h404, 1'b0, 1'b0);    // same index, tag 1 evicts
    req(15'h0004, 32'h4, 1'b0, 1'b0);      // evicted back
    req(15'h0006, 32'h6, 1'b1, 1'b0);

    // Abort a refill with reset while in MISS_WAIT
    cpu_adr = 15'h0C05; cpu_req = 1'b1;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    @(posedge clk);
    #2;
    chk("miss_wait_mem_read", 32'(mem_read), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_mem_read", 32'(mem_read), 32'd0);
    chk("abort_cpu_ready", 32'(cpu_ready), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    req(15'h0C05, 32'hC05, 1'b0, 1'b0);
    req(15'h0004, 32'h4, 1'b0, 1'b0);      // valid bits were cleared

    // Back-to-back with cpu_req held high
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    req(15'h0010, 32'h10, 1'b0, 1'b1);
    req(15'h0011, 32'h11, 1'b1, 1'b1);
    req(15'h0012, 32'h12, 1'b1, 1'b0);
`ifdef CACHE_STATS_EN
    @(posedge clk);
    #1;
    chk("acc_cnt", 32'(acc_cnt), 32'd3);
    chk("hit_cnt", 32'(hit_cnt), 32'd2);
`endif

    repeat (10) @(negedge clk);
    chk("resp_queue_drained", 32'(rq.size()), 32'd0);
    chk("memreq_queue_drained", 32'(mq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_ctrl.md
# cache_ctrl

Direct-mapped, read-only cache and controller sitting between the CPU read port and `mainMem`. On a hit it returns the requested 32-bit word from local storage. On a miss it issues a block read to `mainMem`, captures the four returned words (`data1..data4`) into the line, and forwards the requested word. It is the direct upstream consumer of `mainMem`: it drives `read`/`modAdr` and samples `done`/`data1..4`.

## Interface
- `ADR_W`, 15, word address width; must equal the `mainMem` address width.
- `DATA_W`, 32, word width.
- `INDEX_W`, 8, line index width; 2^INDEX_W lines of 4 words each; tag width = `ADR_W-INDEX_W-2` (5 by default).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_req`  in  1  read request, sampled only in IDLE.
- `cpu_adr`  in  ADR_W  word address; fields are tag = [ADR_W-1:INDEX_W+2], index = [INDEX_W+1:2], offset = [1:0].
- `cpu_data`  out  DATA_W  returned word, registered.
- `cpu_ready`  out  1  one-cycle pulse; `cpu_data` is valid in the same cycle.
- `cpu_hit`  out  1  qualifies `cpu_ready`: 1 = hit, 0 = miss/refill.
- `mem_read`  out  1  to `mainMem` `read`.
- `mem_adr`  out  ADR_W  to `mainMem` `modAdr`; always block-aligned (`{tag,index,2'b00}`).
- `mem_done`  in  1  from `mainMem` `done`.
- `mem_data1..mem_data4`  in  DATA_W each  from `mainMem` `data1..4`; hold words at offsets 0..3.

## Operation
- **Storage.** Per line: valid bit, tag, 4 data words. All valid bits are cleared by reset. Data and tag arrays are not reset.
- **IDLE.** `cpu_req`=1 at an edge latches `cpu_adr` into `adr_q` and moves to LOOKUP. `cpu_adr` is ignored in all other states.
- **LOOKUP.** Hit = valid[idx] && tag[idx]==tag(adr_q).
  - On a hit: at the next edge, `cpu_data` ← word[idx][off], `cpu_ready`=1, `cpu_hit`=1, and the state returns to IDLE.
  - On a miss: at the next edge, `mem_read`=1, `mem_adr`={tag,idx,2'b00}, and the state moves to MISS_WAIT.
- **MISS_WAIT.**
  - `mem_read` and `mem_adr` are held constant.
  - `mem_done` sampled at the first edge in MISS_WAIT is ignored, because it is stale from the previous transaction.
  - At a later edge with `mem_done`=1: write `mem_data1..4` to words 0..3 of the line, write the tag, set valid, and clear `mem_read`. Drive `cpu_data` = `mem_dataN` selected by offset (0→1, 1→2, 2→3, 3→4), `cpu_ready`=1, `cpu_hit`=0. Return to IDLE.
- **Replacement.** A miss unconditionally overwrites the indexed line (direct-mapped, no dirty state, no writes).
- **Outputs.** `cpu_ready` and `cpu_hit` are single-cycle pulses; `cpu_data` holds its value until the next response.

## Timing
- **Reset.** `rst`=1 forces, immediately:
  - state = IDLE;
  - `cpu_data`=0, `cpu_ready`=0, `cpu_hit`=0, `mem_read`=0, `mem_adr`=0;
  - all valid bits = 0;
  - stats counters = 0.

  Reset during MISS_WAIT aborts the refill: the line is not written and `mem_read` drops asynchronously.
- **Hit latency.** Request sampled at edge E, LOOKUP at E+1, `cpu_ready` high for E+1..E+2, so 2 cycles.
- **Miss latency with `mainMem`** (1-cycle `done`):
  - `mem_read` rises after E+1;
  - `mainMem` asserts `done` after E+2, which is ignored at E+2 as the first MISS_WAIT edge;
  - `done` is accepted at E+3, and `cpu_ready` is high for E+3..E+4.

  Slower memories simply extend MISS_WAIT.
- **Back-to-back requests.** A `cpu_req` held high is re-sampled at the first edge in IDLE, i.e. the edge ending the `cpu_ready` cycle. Each request therefore costs at least 2 cycles (hit) or 4 cycles (miss).
- **Same line twice.** A miss followed by a request to the same block hits on the second access.

## Configuration
- `CACHE_STATS_EN` defined adds two ports: `acc_cnt` out 16 and `hit_cnt` out 16.
  - `acc_cnt` increments on every `cpu_ready`.
  - `hit_cnt` increments on `cpu_ready && cpu_hit`.
  - Both wrap from 65535 to 0 and are reset to 0.
- Without `CACHE_STATS_EN`: the ports and counters do not exist, and behaviour is otherwise identical.

## Test plan
- **Cold miss.** Reset, then request adr 0x0005 → `mem_read`=1 with `mem_adr`=0x0004. `mainMem` (Memory[i]=i) returns 4,5,6,7. `cpu_ready` pulses with `cpu_data`=5 and `cpu_hit`=0, 4 cycles after the request edge.
- **Hit after fill.** Then request 0x0007 → `cpu_data`=7, `cpu_hit`=1, 2-cycle latency, `mem_read` stays 0.
- **Conflict eviction.** Request 0x0404 (same index, tag 1) → miss, data 0x404. Then request 0x0004 → miss again, data 4.
- **Reset mid-miss.** Assert `rst` while in MISS_WAIT → `mem_read`=0 and `cpu_ready`=0 immediately. Re-requesting the same address is a miss.
- **Back-to-back.** Hold `cpu_req`=1 over addresses 0x10, 0x11, 0x12 → responses 0x10 (miss), 0x11 (hit), 0x12 (hit). No request is dropped or duplicated.
- **Stats** (`CACHE_STATS_EN`). After the back-to-back scenario, from reset: `acc_cnt`=3, `hit_cnt`=2. Force 65536 accesses → `acc_cnt` wraps to 0.
